// File: rtl/boot_fetch_pkg.sv
// Shared types and constants for the boot-memory fetch block.
// Holds the controller state enum, the default vector address and the wait-state limits.
package boot_fetch_pkg;

    typedef enum logic [2:0] {
        ST_START,
        ST_VEC_HI,
        ST_VEC_LO,
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    localparam logic [7:0] VEC_ADDR_DEFAULT = 8'hFE;
    localparam int         MAX_WAIT_STATES  = 15;
    localparam int         WAIT_W           = 4;

    // Low vector byte sits one above the high byte, wrapping inside the 8-bit space.
    function automatic logic [7:0] vec_lo_addr(input logic [7:0] hi);
        return hi + 8'd1;
    endfunction

    function automatic logic is_access(input state_e s);
        return (s == ST_VEC_HI) || (s == ST_VEC_LO) || (s == ST_ACCESS);
    endfunction

endpackage

// File: rtl/boot_fetch_if.sv
// Boot-memory bus, core request/response handshake and reset-vector outputs.
// master = the fetch block, slave = the surrounding memory and core.
interface boot_fetch_if;
    logic        mem_sel;
    logic [7:0]  mem_a;
    logic [7:0]  mem_din;
    logic        req_valid;
    logic [7:0]  req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_ready;
    logic        vec_valid;
    logic [15:0] vec;

    modport master (
        output mem_sel, mem_a, req_ready, rsp_valid, rsp_data, vec_valid, vec,
        input  mem_din, req_valid, req_addr, rsp_ready
    );

    modport slave (
        input  mem_sel, mem_a, req_ready, rsp_valid, rsp_data, vec_valid, vec,
        output mem_din, req_valid, req_addr, rsp_ready
    );
endinterface

// File: rtl/boot_fetch_bus_wait_timer.sv
// Loadable down-counter that paces one boot-memory access window.
// done is high while the count is zero; the count parks at zero between windows.
module bus_wait_timer
    import boot_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    output logic              done
);
    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/boot_fetch.sv
// Boot-memory bus initiator: fetches the big-endian reset vector after reset,
// then serves single-byte core reads, each stretched by WAIT_STATES extra cycles.
module boot_fetch
    import boot_fetch_pkg::*;
#(
    parameter int         WAIT_STATES = 1,
    parameter logic [7:0] VEC_ADDR    = VEC_ADDR_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    boot_fetch_if.master bus
);
    if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait
        $error("boot_fetch: WAIT_STATES must lie in 0..%0d", MAX_WAIT_STATES);
    end

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

    state_e      state;
    logic        sel_q;
    logic [7:0]  addr_q;
    logic        rdy_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_data_q;
    logic        vec_valid_q;
    logic [15:0] vec_q;

    logic        tmr_load;
    logic        tmr_done;
    logic        accept;

    assign accept = rdy_q && bus.req_valid;

    // The timer is loaded on every edge that enters an access state, so the
    // window always lasts WAIT_STATES+1 cycles regardless of which state it serves.
    always_comb begin
        tmr_load = 1'b0;
        case (state)
            ST_START:  tmr_load = 1'b1;
            ST_VEC_HI: tmr_load = tmr_done;
            ST_IDLE:   tmr_load = accept;
            default:   tmr_load = 1'b0;
        endcase
    end

    bus_wait_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (WAIT_LOAD),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_START;
            sel_q       <= 1'b0;
            addr_q      <= 8'h00;
            rdy_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            vec_valid_q <= 1'b0;
            vec_q       <= 16'h0000;
        end else begin
            case (state)
                ST_START: begin
                    sel_q  <= 1'b1;
                    addr_q <= VEC_ADDR;
                    state  <= ST_VEC_HI;
                end
                ST_VEC_HI: begin
                    if (tmr_done) begin
                        vec_q[15:8] <= bus.mem_din;
                        addr_q      <= vec_lo_addr(VEC_ADDR);
                        state       <= ST_VEC_LO;
                    end
                end
                ST_VEC_LO: begin
                    if (tmr_done) begin
                        vec_q[7:0]  <= bus.mem_din;
                        vec_valid_q <= 1'b1;
                        sel_q       <= 1'b0;
                        rdy_q       <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    // addr_q doubles as the latched request address
                    if (accept) begin
                        sel_q  <= 1'b1;
                        addr_q <= bus.req_addr;
                        rdy_q  <= 1'b0;
                        state  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (tmr_done) begin
                        rsp_data_q  <= bus.mem_din;
                        rsp_valid_q <= 1'b1;
                        sel_q       <= 1'b0;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rdy_q       <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    sel_q <= 1'b0;
                    rdy_q <= 1'b0;
                    state <= ST_START;
                end
            endcase
        end
    end

    assign bus.mem_sel   = sel_q;
    assign bus.mem_a     = addr_q;
    assign bus.req_ready = rdy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.vec_valid = vec_valid_q;
    assign bus.vec       = vec_q;

    a_sel_only_in_access: assert property (@(posedge clk) disable iff (!rst_n)
        sel_q |-> is_access(state));
    a_ready_only_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
        rdy_q == (state == ST_IDLE));
    a_rsp_only_in_resp: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid_q == (state == ST_RESP));

endmodule
